// File: rtl/mem_wb_stage_pkg.sv
// Shared widths, funct encodings and the write-back packet used by the MEM/WB stage.
package mem_wb_stage_pkg;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned REG_W   = 3;
  localparam int unsigned FUNCT_W = 5;

  localparam logic [FUNCT_W-1:0] FUNCT_LD = 5'b01010;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [REG_W-1:0]  rd;
    logic              wr;
  } wb_pkt_t;

endpackage

// File: rtl/mem_wb_stage_data_ram.sv
// Byte-wide data RAM: synchronous write, asynchronous read, address wrapped to DEPTH.
module mem_wb_stage_data_ram
  import mem_wb_stage_pkg::*;
#(
  parameter int unsigned DEPTH = 256
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [IDX_W-1:0]  idx_c;

  // Only the low address bits select a word; upper bits alias.
  assign idx_c = addr_i[IDX_W-1:0];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[idx_c] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[idx_c];

endmodule

// File: rtl/mem_wb_stage.sv
// Memory-access stage: data RAM loads/stores, jump resolution, registered write-back packet
// and a combinational forwarding view of the instruction currently in MEM.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = 256
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [DATA_W-1:0]  immed,
  input  logic [ADDR_W-1:0]  memAddr,
  input  logic [DATA_W-1:0]  ALUresult,
  input  logic [DATA_W-1:0]  memWriteData,
  input  logic               zeroFlag,
  input  logic               memReadWrite,
  input  logic               regWrite,
  input  logic [REG_W-1:0]   targetReg,
  input  logic [FUNCT_W-1:0] funct,
  input  logic               jumpEnable,
  input  logic               stall,
  output logic [DATA_W-1:0]  wbData_o,
  output logic [REG_W-1:0]   wbReg_o,
  output logic               wbWrite_o,
  output logic               jumpTaken_o,
  output logic [DATA_W-1:0]  jumpTarget_o,
  output logic [DATA_W-1:0]  fwdData_o,
  output logic [REG_W-1:0]   fwdReg_o,
  output logic               fwdValid_o
);

  logic [DATA_W-1:0] ram_rdata;
  logic              ram_we_c;
  logic              is_load_c;
  wb_pkt_t           wb_d, wb_q;
  logic              jump_taken_d, jump_taken_q;
  logic [DATA_W-1:0] jump_target_d, jump_target_q;

  // Writes are blocked while stalled and while reset is held.
  assign ram_we_c = memReadWrite & ~stall & rst_n;

  mem_wb_stage_data_ram #(
    .DEPTH (MEM_DEPTH)
  ) u_data_ram (
    .clk     (clk),
    .we_i    (ram_we_c),
    .addr_i  (memAddr),
    .wdata_i (memWriteData),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    is_load_c     = 1'b0;
    wb_d          = '0;
    jump_taken_d  = 1'b0;
    jump_target_d = jump_target_q;

    // A store outranks a load encoding in the same instruction.
    is_load_c     = regWrite & ~memReadWrite & (funct == FUNCT_LD);
    wb_d.data     = is_load_c ? ram_rdata : ALUresult;
    wb_d.rd       = targetReg;
    wb_d.wr       = regWrite & ~memReadWrite;
    jump_taken_d  = jumpEnable & zeroFlag;
    if (jump_taken_d) begin
      jump_target_d = immed;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_q          <= '0;
      jump_taken_q  <= 1'b0;
      jump_target_q <= '0;
    end else if (!stall) begin
      wb_q          <= wb_d;
      jump_taken_q  <= jump_taken_d;
      jump_target_q <= jump_target_d;
    end
  end

  assign wbData_o     = wb_q.data;
  assign wbReg_o      = wb_q.rd;
  assign wbWrite_o    = wb_q.wr;
  assign jumpTaken_o  = jump_taken_q;
  assign jumpTarget_o = jump_target_q;

  assign fwdData_o  = wb_d.data;
  assign fwdReg_o   = targetReg;
  assign fwdValid_o = regWrite & ~stall;

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Memory-access stage of the 8-bit pipeline; sole consumer of the EX/MEM pipeline-register outputs.
- Performs data-memory loads and stores against an internal byte-addressed data RAM.
- Resolves jumps.
- Registers the write-back packet (data, target register, write enable) for the register file.
- Exposes a combinational forwarding view of the instruction currently in MEM.

Parameters:
- MEM_DEPTH, 256, number of 8-bit data-memory words; address is memAddr modulo MEM_DEPTH.
- FUNCT_LD, 5'b01010, funct code that selects a load; any other funct with regWrite=1 writes back ALUresult.

Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- immed  in  8  jump target from EX/MEM
- memAddr  in  8  data-memory address
- ALUresult  in  8  ALU result
- memWriteData  in  8  store data
- zeroFlag  in  1  ALU zero flag
- memReadWrite  in  1  1 = store this cycle
- regWrite  in  1  instruction writes a register
- targetReg  in  3  destination register
- funct  in  5  instruction function code
- jumpEnable  in  1  instruction is a conditional jump
- stall  in  1  hold MEM/WB outputs and suppress the store
- wbData_o  out  8  registered write-back data
- wbReg_o  out  3  registered destination register
- wbWrite_o  out  1  registered register-file write enable
- jumpTaken_o  out  1  registered one-cycle jump pulse; drives upstream jumpClear
- jumpTarget_o  out  8  registered jump target; valid while jumpTaken_o=1
- fwdData_o  out  8  combinational value this instruction will write back
- fwdReg_o  out  3  combinational targetReg
- fwdValid_o  out  1  combinational regWrite & ~stall

Behaviour:
- Reset (rst_n=0, asynchronous): wbData_o=0, wbReg_o=0, wbWrite_o=0, jumpTaken_o=0, jumpTarget_o=0.
  - Data RAM is not reset; its contents are undefined until written.
- Store: on a rising edge with memReadWrite=1, stall=0 and rst_n=1, write RAM[memAddr] <= memWriteData.
  - A store never asserts wbWrite_o, even if regWrite=1.
- Load: when funct==FUNCT_LD and regWrite=1, the selected data is the asynchronous read of RAM[memAddr]. Otherwise the selected data is ALUresult.
- Latency: one cycle from the EX/MEM input to the wb* outputs. On each rising edge with stall=0:
  - wbData_o <= selected data
  - wbReg_o <= targetReg
  - wbWrite_o <= regWrite & ~memReadWrite
- Jump: on each rising edge with stall=0:
  - jumpTaken_o <= jumpEnable & zeroFlag
  - jumpTarget_o <= immed when taken; otherwise it holds its previous value.
  - jumpTaken_o is high for exactly one cycle per taken jump. The upstream flush turns the following EX/MEM slots into zeros, which this block handles as a NOP (regWrite=0, memReadWrite=0).
- Stall: with stall=1, all registered outputs hold and no RAM write occurs.
  - If stall=1 coincides with a taken jump, jumpTaken_o keeps its current value. The jump is registered on the first unstalled edge.
- Store then load to the same address in back-to-back cycles: the load returns the newly stored byte. The write completes at the edge before the load's read.
- Load and store in the same instruction is not possible. If memReadWrite=1 and funct==FUNCT_LD, the store takes priority and wbWrite_o=0.
- Address wrap: when MEM_DEPTH<256, the address uses only the low log2(MEM_DEPTH) bits.
- Reset mid-operation: outputs clear immediately and no write occurs while rst_n=0. The RAM keeps its contents.
- Forwarding outputs are purely combinational from the current inputs and the RAM. They carry no reset dependency beyond the RAM contents.

Decomposition:
- Shared package: FUNCT_LD and the other funct encodings, REG_W=3, DATA_W=8.
- One natural sub-module: data_ram, a MEM_DEPTH x 8 array with a synchronous write port and an asynchronous read port. It is instantiated here and owns the address-wrap logic.

Test Plan:
- Reset, then rst_n released with all inputs 0: wbData_o=0, wbWrite_o=0, jumpTaken_o=0. Assert rst_n=0 mid-run: outputs go to 0 before the next clock edge.
- ALU write-back: regWrite=1, funct=0, ALUresult=8'h5A, targetReg=3 -> one cycle later wbData_o=8'h5A, wbReg_o=3, wbWrite_o=1.
- Store then load: cycle N store memAddr=8'h10, memWriteData=8'hC3 (wbWrite_o=0 at N+1); cycle N+1 load memAddr=8'h10, targetReg=5 -> at N+2 wbData_o=8'hC3, wbReg_o=5, wbWrite_o=1.
- Jump: jumpEnable=1, zeroFlag=1, immed=8'h2E -> jumpTaken_o=1 for exactly one cycle with jumpTarget_o=8'h2E. With zeroFlag=0 instead -> jumpTaken_o stays 0.
- Stall: store to 8'h20 with stall=1 for two cycles, then a load from 8'h20 -> load returns the old RAM value, and the wb outputs hold during the stall.
- Forwarding: load from 8'h10 (holding 8'hC3) with stall=0 -> same-cycle fwdData_o=8'hC3, fwdValid_o=1. Raising stall -> fwdValid_o=0.
